pipe_stage_skid: RTL



---
 rtl/pipe_pkg.sv | 30 +++
 rtl/pipe_stage_skid_slot.sv | 54 +++++
 rtl/pipe_stage_skid.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// Module   : pipe_pkg
// Brief    : Shared types and defaults for the pipeline stage registers.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

  localparam int INSTR_W_DEF = 20;
  localparam int DATA_W_DEF  = 20;
  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR_DEF = '0;

  // Occupancy of a skid stage; the encoding equals the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

  // Payload carried between stages at the default widths.
  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [DATA_W_DEF-1:0]  result;
    logic                   zero;
  } payload_t;

endpackage

`default_nettype wire

// File: rtl/pipe_stage_skid_slot.sv
// ----------------------------------------------------------------------------
// Module   : pipe_slot
// Brief    : One payload register plus valid bit with load/clear/hold control.
//            Clearing (or reset) returns the slot to the bubble payload.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module pipe_slot #(
  parameter int                 INSTR_W   = 20,
  parameter int                 DATA_W    = 20,
  parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}}
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [DATA_W-1:0]  d_result,
  input  logic               d_zero,
  output logic               q_valid,
  output logic [INSTR_W-1:0] q_instr,
  output logic [DATA_W-1:0]  q_result,
  output logic               q_zero
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [DATA_W-1:0]  r_result;
  logic               r_zero;

  // Reset and clear both force the bubble; load captures; otherwise hold.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_valid  <= 1'b0;
      r_instr  <= NOP_INSTR;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (load) begin
      r_valid  <= 1'b1;
      r_instr  <= d_instr;
      r_result <= d_result;
      r_zero   <= d_zero;
    end
  end

  assign q_valid  = r_valid;
  assign q_instr  = r_instr;
  assign q_result = r_result;
  assign q_zero   = r_zero;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_skid.sv
// ----------------------------------------------------------------------------
// Module   : pipe_stage_skid
// Brief    : Parametrised inter-stage pipeline register with valid/ready
//            handshake, flush, and an optional two-entry skid buffer that
//            registers the upstream ready path.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                 INSTR_W   = INSTR_W_DEF,
  parameter int                 DATA_W    = DATA_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}},
  parameter bit                 SKID      = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [DATA_W-1:0]  in_result,
  input  logic               in_zero,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [DATA_W-1:0]  out_result,
  output logic               out_zero,
  output logic [1:0]         occupancy
);

  logic w_in_xfer;
  logic w_out_xfer;

  logic               w_main_load;
  logic               w_main_clear;
  logic [INSTR_W-1:0] w_main_instr;
  logic [DATA_W-1:0]  w_main_result;
  logic               w_main_zero;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  // Main slot always drives the stage outputs.
  pipe_slot #(
    .INSTR_W   (INSTR_W),
    .DATA_W    (DATA_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_main (
    .clock    (clock),
    .reset    (reset),
    .load     (w_main_load),
    .clear    (w_main_clear),
    .d_instr  (w_main_instr),
    .d_result (w_main_result),
    .d_zero   (w_main_zero),
    .q_valid  (out_valid),
    .q_instr  (out_instr),
    .q_result (out_result),
    .q_zero   (out_zero)
  );

  generate
    if (SKID) begin : g_skid
      occ_state_t         r_state;
      occ_state_t         w_state_nxt;
      logic               r_in_ready;
      logic               w_main_from_skid;
      logic               w_skid_load;
      logic               w_skid_clear;
      logic               w_skid_valid;
      logic [INSTR_W-1:0] w_skid_instr;
      logic [DATA_W-1:0]  w_skid_result;
      logic               w_skid_zero;

      // Overflow slot; only ever filled while main is held by back-pressure.
      pipe_slot #(
        .INSTR_W   (INSTR_W),
        .DATA_W    (DATA_W),
        .NOP_INSTR (NOP_INSTR)
      ) u_skid (
        .clock    (clock),
        .reset    (reset),
        .load     (w_skid_load),
        .clear    (w_skid_clear),
        .d_instr  (in_instr),
        .d_result (in_result),
        .d_zero   (in_zero),
        .q_valid  (w_skid_valid),
        .q_instr  (w_skid_instr),
        .q_result (w_skid_result),
        .q_zero   (w_skid_zero)
      );

      // Occupancy transition and slot controls; flush overrides every transfer.
      always_comb begin
        w_state_nxt      = r_state;
        w_main_load      = 1'b0;
        w_main_clear     = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;
        if (flush) begin
          w_state_nxt  = EMPTY;
          w_main_clear = 1'b1;
          w_skid_clear = 1'b1;
        end else begin
          case (r_state)
            EMPTY: begin
              if (w_in_xfer) begin
                w_main_load = 1'b1;
                w_state_nxt = ONE;
              end
            end
            ONE: begin
              if (w_in_xfer && w_out_xfer) begin
                w_main_load = 1'b1;
              end else if (w_in_xfer) begin
                w_skid_load = 1'b1;
                w_state_nxt = TWO;
              end else if (w_out_xfer) begin
                w_main_clear = 1'b1;
                w_state_nxt  = EMPTY;
              end
            end
            TWO: begin
              if (w_out_xfer) begin
                w_main_load      = 1'b1;
                w_main_from_skid = 1'b1;
                w_skid_clear     = 1'b1;
                w_state_nxt      = ONE;
              end
            end
            default: begin
              w_state_nxt  = EMPTY;
              w_main_clear = 1'b1;
              w_skid_clear = 1'b1;
            end
          endcase
        end
      end

      assign w_main_instr  = w_main_from_skid ? w_skid_instr  : in_instr;
      assign w_main_result = w_main_from_skid ? w_skid_result : in_result;
      assign w_main_zero   = w_main_from_skid ? w_skid_zero   : in_zero;

      // Occupancy and the registered upstream ready (room for one more entry).
      always_ff @(posedge clock) begin
        if (reset) begin
          r_state    <= EMPTY;
          r_in_ready <= 1'b1;
        end else begin
          r_state    <= w_state_nxt;
          r_in_ready <= (w_state_nxt != TWO);
        end
      end

      assign in_ready  = r_in_ready;
      assign occupancy = r_state;
    end else begin : g_no_skid
      // Single slot: accept when empty or when the held entry leaves now.
      assign in_ready      = ~out_valid | out_ready;
      assign w_main_load   = ~flush & w_in_xfer;
      assign w_main_clear  = flush | (~w_in_xfer & w_out_xfer);
      assign w_main_instr  = in_instr;
      assign w_main_result = in_result;
      assign w_main_zero   = in_zero;
      assign occupancy     = {1'b0, out_valid};
    end
  endgenerate

endmodule

`default_nettype wire
